// File: rtl/speed_ctrl.sv
// speed_ctrl: debounced up/down key speed-level controller with auto-repeat
//
// Ports:
//   iCLK       in   system clock, rising edge
//   iRST       in   asynchronous active-high reset
//   iKEY_UP_n  in   raw up key, low = pressed
//   iKEY_DN_n  in   raw down key, low = pressed
//   oLEVEL     out  registered speed level [WIDTH-1:0]
//   oENABLE    out  one-cycle pulse when oLEVEL takes a new value
//   oUP_DOWN   out  direction of the last step (1 = up), held between steps
//   oAT_MAX    out  oLEVEL == MAX_LEVEL
//   oAT_MIN    out  oLEVEL == MIN_LEVEL
module speed_ctrl #(
   parameter int WIDTH           = 4,
   parameter int MIN_LEVEL       = 0,
   parameter int MAX_LEVEL       = 9,
   parameter int RESET_LEVEL     = 0,
   parameter int DEBOUNCE_CYCLES = 500000,
   parameter int REPEAT_EN       = 1,
   parameter int REPEAT_DELAY    = 25000000,
   parameter int REPEAT_PERIOD   = 5000000,
   parameter int WRAP            = 0
) (
   input  logic             iCLK,
   input  logic             iRST,
   input  logic             iKEY_UP_n,
   input  logic             iKEY_DN_n,
   output logic [WIDTH-1:0] oLEVEL,
   output logic             oENABLE,
   output logic             oUP_DOWN,
   output logic             oAT_MAX,
   output logic             oAT_MIN
);
   localparam int DW      = $clog2(DEBOUNCE_CYCLES + 1);
   localparam int RPT_MAX = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
   localparam int RW      = $clog2(RPT_MAX + 1);
   localparam logic [DW-1:0]    DB_LAST = DW'(DEBOUNCE_CYCLES - 1);
   localparam logic [RW-1:0]    RPT_DLY = RW'(REPEAT_DELAY);
   localparam logic [RW-1:0]    RPT_PER = RW'(REPEAT_PERIOD);
   localparam logic [RW-1:0]    RPT_ONE = RW'(1);
   localparam logic [WIDTH-1:0] L_MIN   = WIDTH'(MIN_LEVEL);
   localparam logic [WIDTH-1:0] L_MAX   = WIDTH'(MAX_LEVEL);
   localparam logic [WIDTH-1:0] L_RST   = WIDTH'(RESET_LEVEL);
   localparam logic [1:0] S_IDLE = 2'd0;
   localparam logic [1:0] S_UP   = 2'd1;
   localparam logic [1:0] S_DN   = 2'd2;
   localparam logic [1:0] S_BOTH = 2'd3;

   logic [1:0]       w_key_n;
   logic [1:0]       w_pressed;
   logic             w_up;
   logic             w_dn;
   logic             w_own;
   logic             w_oth;
   logic             w_rpt_fire;
   logic [1:0]       r_state;
   logic [1:0]       w_state_nx;
   logic [RW-1:0]    r_rpt;
   logic [RW-1:0]    w_rpt_nx;
   logic             w_step;
   logic             w_dir;
   logic             w_moves;
   logic [WIDTH-1:0] w_lvl_nx;

   assign w_key_n = {iKEY_DN_n, iKEY_UP_n};

   // Per key: two-flop synchroniser followed by a counter that must see
   // DEBOUNCE_CYCLES consecutive differing samples before the level is accepted.
   for (genvar k = 0; k < 2; k++) begin : g_key
      logic [1:0]    r_sync;
      logic          r_deb_n;
      logic [DW-1:0] r_cnt;
      always_ff @(posedge iCLK or posedge iRST)
         if (iRST) begin
            r_sync  <= 2'b11;
            r_deb_n <= 1'b1;
            r_cnt   <= '0;
         end else begin
            r_sync <= {r_sync[0], w_key_n[k]};
            if (r_sync[1] == r_deb_n)
               r_cnt <= '0;
            else if (r_cnt == DB_LAST) begin
               r_deb_n <= r_sync[1];
               r_cnt   <= '0;
            end else
               r_cnt <= r_cnt + 1'b1;
         end
      assign w_pressed[k] = ~r_deb_n;
   end

   assign w_up  = w_pressed[0];
   assign w_dn  = w_pressed[1];
   assign w_own = (r_state == S_UP) ? w_up : w_dn;
   assign w_oth = (r_state == S_UP) ? w_dn : w_up;
   // A repeat that lands right after a level change waits one cycle so that
   // oENABLE can never be high in two consecutive cycles.
   assign w_rpt_fire = (r_rpt <= RPT_ONE) && !oENABLE;

   always_comb begin
      w_state_nx = r_state;
      w_rpt_nx   = r_rpt;
      w_step     = 1'b0;
      w_dir      = 1'b0;
      case (r_state)
         S_IDLE:
            if (w_up && w_dn)
               w_state_nx = S_BOTH;
            else if (w_up || w_dn) begin
               w_state_nx = w_up ? S_UP : S_DN;
               w_rpt_nx   = RPT_DLY;
               w_step     = 1'b1;
               w_dir      = w_up;
            end
         S_UP, S_DN:
            if (!w_own) begin
               w_state_nx = S_IDLE;
               w_rpt_nx   = '0;
            end else if (w_oth) begin
               w_state_nx = S_BOTH;
               w_rpt_nx   = '0;
            end else if (REPEAT_EN != 0) begin
               w_dir = (r_state == S_UP);
               if (w_rpt_fire) begin
                  w_step   = 1'b1;
                  w_rpt_nx = RPT_PER;
               end else if (r_rpt > RPT_ONE)
                  w_rpt_nx = r_rpt - 1'b1;
            end
         default:
            w_state_nx = (!w_up && !w_dn) ? S_IDLE : S_BOTH;
      endcase
   end

   assign oAT_MAX  = (oLEVEL == L_MAX);
   assign oAT_MIN  = (oLEVEL == L_MIN);
   // Increments only happen below MAX and decrements only above MIN, so the
   // WIDTH-bit arithmetic never overflows.
   assign w_lvl_nx = w_dir ? (oAT_MAX ? ((WRAP != 0) ? L_MIN : oLEVEL) : oLEVEL + 1'b1)
                           : (oAT_MIN ? ((WRAP != 0) ? L_MAX : oLEVEL) : oLEVEL - 1'b1);
   assign w_moves  = w_step && ((WRAP != 0) || (w_dir ? !oAT_MAX : !oAT_MIN));

   always_ff @(posedge iCLK or posedge iRST)
      if (iRST) begin
         r_state  <= S_IDLE;
         r_rpt    <= '0;
         oLEVEL   <= L_RST;
         oENABLE  <= 1'b0;
         oUP_DOWN <= 1'b0;
      end else begin
         r_state <= w_state_nx;
         r_rpt   <= w_rpt_nx;
         oENABLE <= w_moves;
         if (w_moves)
            oLEVEL <= w_lvl_nx;
         if (w_step)
            oUP_DOWN <= w_dir;
      end
endmodule

// File: tb/tb_speed_ctrl.sv
// tb_speed_ctrl: directed self-checking bench for speed_ctrl (saturating and wrapping instances)
module tb_speed_ctrl;
   logic clk = 1'b0;
   logic rst = 1'b1;
   logic up1 = 1'b1, dn1 = 1'b1, up2 = 1'b1, dn2 = 1'b1;
   logic [3:0] lvl1, lvl2;
   logic en1, ud1, amax1, amin1, en2, ud2, amax2, amin2;
   int n_chk = 0;
   int n_fail = 0;

   always #5 clk = ~clk;

   speed_ctrl #(.WIDTH(4), .MIN_LEVEL(0), .MAX_LEVEL(9), .RESET_LEVEL(5), .DEBOUNCE_CYCLES(4),
                .REPEAT_EN(1), .REPEAT_DELAY(20), .REPEAT_PERIOD(8), .WRAP(0)) dut_sat (
      .iCLK(clk), .iRST(rst), .iKEY_UP_n(up1), .iKEY_DN_n(dn1), .oLEVEL(lvl1),
      .oENABLE(en1), .oUP_DOWN(ud1), .oAT_MAX(amax1), .oAT_MIN(amin1));

   speed_ctrl #(.WIDTH(4), .MIN_LEVEL(0), .MAX_LEVEL(9), .RESET_LEVEL(5), .DEBOUNCE_CYCLES(4),
                .REPEAT_EN(1), .REPEAT_DELAY(20), .REPEAT_PERIOD(8), .WRAP(1)) dut_wrap (
      .iCLK(clk), .iRST(rst), .iKEY_UP_n(up2), .iKEY_DN_n(dn2), .oLEVEL(lvl2),
      .oENABLE(en2), .oUP_DOWN(ud2), .oAT_MAX(amax2), .oAT_MIN(amin2));

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic run(input int n, output int p1, output int p2);
      p1 = 0;
      p2 = 0;
      repeat (n) begin
         tick();
         if (en1) p1++;
         if (en2) p2++;
      end
   endtask

   task automatic test_reset();
      rst = 1'b1;
      repeat (3) tick();
      rst = 1'b0;
      repeat (10) tick();
      n_chk++; if (lvl1 !== 4'd5) begin n_fail++; $display("FAIL reset_level: got %0d want 5", lvl1); end
      n_chk++; if (en1 !== 1'b0) begin n_fail++; $display("FAIL reset_enable: got %b want 0", en1); end
      n_chk++; if (ud1 !== 1'b0) begin n_fail++; $display("FAIL reset_updown: got %b want 0", ud1); end
      n_chk++; if (amax1 !== 1'b0) begin n_fail++; $display("FAIL reset_at_max: got %b want 0", amax1); end
      n_chk++; if (amin1 !== 1'b0) begin n_fail++; $display("FAIL reset_at_min: got %b want 0", amin1); end
      n_chk++; if (lvl2 !== 4'd5) begin n_fail++; $display("FAIL reset_level_wrap: got %0d want 5", lvl2); end
   endtask

   task automatic test_glitch_press();
      int p1, p2, g;
      g = 0;
      up1 = 1'b0; run(2, p1, p2); g += p1;
      up1 = 1'b1; run(4, p1, p2); g += p1;
      up1 = 1'b0; run(2, p1, p2); g += p1;
      up1 = 1'b1; run(6, p1, p2); g += p1;
      n_chk++; if (g !== 0 || lvl1 !== 4'd5) begin n_fail++; $display("FAIL glitch: pulses %0d level %0d want 0 and 5", g, lvl1); end
      up1 = 1'b0;
      run(6, p1, p2);
      n_chk++; if (p1 !== 0) begin n_fail++; $display("FAIL press_early: pulses %0d want 0", p1); end
      tick();
      n_chk++; if (en1 !== 1'b1) begin n_fail++; $display("FAIL press_pulse: enable %b want 1", en1); end
      n_chk++; if (lvl1 !== 4'd6) begin n_fail++; $display("FAIL press_level: got %0d want 6", lvl1); end
      n_chk++; if (ud1 !== 1'b1) begin n_fail++; $display("FAIL press_updown: got %b want 1", ud1); end
      run(5, p1, p2);
      n_chk++; if (p1 !== 0) begin n_fail++; $display("FAIL press_hold: pulses %0d want 0", p1); end
      up1 = 1'b1;
      run(12, p1, p2);
      n_chk++; if (p1 !== 0 || lvl1 !== 4'd6) begin n_fail++; $display("FAIL release: pulses %0d level %0d want 0 and 6", p1, lvl1); end
   endtask

   task automatic test_down_repeat();
      int p1, p2;
      logic exp_en;
      logic [3:0] exp_lvl;
      dn1 = 1'b0;
      run(6, p1, p2);
      n_chk++; if (p1 !== 0) begin n_fail++; $display("FAIL down_early: pulses %0d want 0", p1); end
      tick();
      n_chk++; if (en1 !== 1'b1 || lvl1 !== 4'd5) begin n_fail++; $display("FAIL down_first: enable %b level %0d want 1 and 5", en1, lvl1); end
      exp_lvl = 4'd5;
      for (int off = 1; off < 70; off++) begin
         tick();
         exp_en = (off == 20) || (off == 28) || (off == 36) || (off == 44) || (off == 52);
         if (exp_en) exp_lvl = exp_lvl - 4'd1;
         n_chk++; if (en1 !== exp_en) begin n_fail++; $display("FAIL down_rpt_en t0+%0d: got %b want %b", off, en1, exp_en); end
         n_chk++; if (lvl1 !== exp_lvl) begin n_fail++; $display("FAIL down_rpt_lvl t0+%0d: got %0d want %0d", off, lvl1, exp_lvl); end
      end
      n_chk++; if (amin1 !== 1'b1) begin n_fail++; $display("FAIL down_at_min: got %b want 1", amin1); end
      n_chk++; if (ud1 !== 1'b0) begin n_fail++; $display("FAIL down_updown: got %b want 0", ud1); end
      dn1 = 1'b1;
      run(12, p1, p2);
   endtask

   task automatic test_saturate_wrap();
      int p1, p2;
      dn1 = 1'b0; run(12, p1, p2);
      n_chk++; if (p1 !== 0 || lvl1 !== 4'd0) begin n_fail++; $display("FAIL sat_min: pulses %0d level %0d want 0 and 0", p1, lvl1); end
      dn1 = 1'b1; run(12, p1, p2);
      up1 = 1'b0; run(90, p1, p2);
      n_chk++; if (p1 !== 9 || lvl1 !== 4'd9) begin n_fail++; $display("FAIL climb: pulses %0d level %0d want 9 and 9", p1, lvl1); end
      n_chk++; if (amax1 !== 1'b1 || amin1 !== 1'b0) begin n_fail++; $display("FAIL climb_flags: max %b min %b want 1 0", amax1, amin1); end
      up1 = 1'b1; run(12, p1, p2);
      up1 = 1'b0; run(12, p1, p2);
      n_chk++; if (p1 !== 0 || lvl1 !== 4'd9) begin n_fail++; $display("FAIL sat_max: pulses %0d level %0d want 0 and 9", p1, lvl1); end
      n_chk++; if (ud1 !== 1'b1) begin n_fail++; $display("FAIL sat_max_updown: got %b want 1", ud1); end
      up1 = 1'b1; run(12, p1, p2);
      up2 = 1'b0; run(43, p1, p2);
      n_chk++; if (p2 !== 4 || lvl2 !== 4'd9) begin n_fail++; $display("FAIL wrap_climb: pulses %0d level %0d want 4 and 9", p2, lvl2); end
      up2 = 1'b1; run(12, p1, p2);
      up2 = 1'b0; run(12, p1, p2);
      n_chk++; if (p2 !== 1 || lvl2 !== 4'd0) begin n_fail++; $display("FAIL wrap_step: pulses %0d level %0d want 1 and 0", p2, lvl2); end
      n_chk++; if (amin2 !== 1'b1 || ud2 !== 1'b1) begin n_fail++; $display("FAIL wrap_flags: min %b updown %b want 1 1", amin2, ud2); end
      up2 = 1'b1; run(12, p1, p2);
   endtask

   task automatic test_both_held();
      int p1, p2;
      up2 = 1'b0;
      run(6, p1, p2);
      tick();
      n_chk++; if (en2 !== 1'b1 || lvl2 !== 4'd1) begin n_fail++; $display("FAIL both_first: enable %b level %0d want 1 and 1", en2, lvl2); end
      run(21, p1, p2);
      n_chk++; if (p2 !== 1 || lvl2 !== 4'd2) begin n_fail++; $display("FAIL both_repeat: pulses %0d level %0d want 1 and 2", p2, lvl2); end
      dn2 = 1'b0;
      run(40, p1, p2);
      n_chk++; if (p2 !== 0 || lvl2 !== 4'd2) begin n_fail++; $display("FAIL both_hold: pulses %0d level %0d want 0 and 2", p2, lvl2); end
      dn2 = 1'b1;
      run(30, p1, p2);
      n_chk++; if (p2 !== 0 || lvl2 !== 4'd2) begin n_fail++; $display("FAIL both_dn_release: pulses %0d level %0d want 0 and 2", p2, lvl2); end
      up2 = 1'b1;
      run(12, p1, p2);
      up2 = 1'b0;
      run(12, p1, p2);
      n_chk++; if (p2 !== 1 || lvl2 !== 4'd3) begin n_fail++; $display("FAIL both_fresh: pulses %0d level %0d want 1 and 3", p2, lvl2); end
      up2 = 1'b1;
      run(12, p1, p2);
   endtask

   task automatic test_reset_mid_press();
      int p1, p2;
      up1 = 1'b0;
      run(6, p1, p2);
      tick();
      run(17, p1, p2);
      rst = 1'b1;
      #1;
      n_chk++; if (lvl1 !== 4'd5 || en1 !== 1'b0) begin n_fail++; $display("FAIL rst_async: level %0d enable %b want 5 and 0", lvl1, en1); end
      n_chk++; if (lvl2 !== 4'd5 || ud1 !== 1'b0) begin n_fail++; $display("FAIL rst_async2: level2 %0d updown %b want 5 and 0", lvl2, ud1); end
      run(3, p1, p2);
      n_chk++; if (p1 !== 0) begin n_fail++; $display("FAIL rst_hold: pulses %0d want 0", p1); end
      rst = 1'b0;
      run(6, p1, p2);
      n_chk++; if (p1 !== 0) begin n_fail++; $display("FAIL rst_early: pulses %0d want 0", p1); end
      tick();
      n_chk++; if (en1 !== 1'b1 || lvl1 !== 4'd6) begin n_fail++; $display("FAIL rst_fresh: enable %b level %0d want 1 and 6", en1, lvl1); end
      run(12, p1, p2);
      n_chk++; if (p1 !== 0 || lvl1 !== 4'd6) begin n_fail++; $display("FAIL rst_after: pulses %0d level %0d want 0 and 6", p1, lvl1); end
      up1 = 1'b1;
      run(12, p1, p2);
   endtask

   initial begin
      test_reset();
      test_glitch_press();
      test_down_repeat();
      test_saturate_wrap();
      test_both_held();
      test_reset_mid_press();
      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end
endmodule

// File: doc/speed_ctrl.md
Name: speed_ctrl

Overview:
- Parametrised speed-level controller driven by two active-low push-buttons (up/down).
- Synchronises and debounces both keys and detects presses.
- Optionally auto-repeats while a key is held.
- Maintains a bounded speed level register, with saturation or wrap at the bounds.
- Sits between the board keys and the speed/frequency generator. Emits a one-cycle enable pulse plus direction for downstream counters, and the absolute level.

Parameters:
- WIDTH, 4, width of the speed level register.
- MIN_LEVEL, 0, lowest legal level.
- MAX_LEVEL, 9, highest legal level. Constraint: MIN_LEVEL < MAX_LEVEL <= 2**WIDTH-1.
- RESET_LEVEL, 0, level loaded on reset. Constraint: MIN_LEVEL..MAX_LEVEL.
- DEBOUNCE_CYCLES, 500000, consecutive stable samples required to accept a key level change. Must be >= 1.
- REPEAT_EN, 1, 1 enables auto-repeat while a single key is held.
- REPEAT_DELAY, 25000000, cycles from the first step to the first repeat step. Must be >= 1.
- REPEAT_PERIOD, 5000000, cycles between subsequent repeat steps. Must be >= 1.
- WRAP, 0, 0 saturates at the bounds; 1 wraps MAX<->MIN.

Ports:
- iCLK  input  1  system clock, all logic on its rising edge.
- iRST  input  1  reset; asynchronous and active-high.
- iKEY_UP_n  input  1  up key, raw, asynchronous, low = pressed.
- iKEY_DN_n  input  1  down key, raw, asynchronous, low = pressed.
- oLEVEL  output  WIDTH  current speed level, registered.
- oENABLE  output  1  one-cycle pulse, high in the cycle oLEVEL takes its new value.
- oUP_DOWN  output  1  direction of the last step (1 = up, 0 = down), registered, held between steps.
- oAT_MAX  output  1  high while oLEVEL == MAX_LEVEL.
- oAT_MIN  output  1  high while oLEVEL == MIN_LEVEL.

Behaviour:

Reset:
- Asserting iRST immediately forces: oLEVEL = RESET_LEVEL, oENABLE = 0, oUP_DOWN = 0, FSM = IDLE.
- Synchroniser flops = 1, debounced keys = released, all counters = 0.
- oAT_MAX/oAT_MIN reflect RESET_LEVEL.
- Reset mid-press aborts any repeat with no pulse. A key still held after release of iRST is re-debounced and produces exactly one fresh step.

Input path:
- Per key: 2-flop synchroniser, then a debouncer.
- The debounced value changes only after DEBOUNCE_CYCLES consecutive synchronised samples that differ from it. Any sample equal to the current debounced value clears the counter.

Latency:
- The first edge sampling a stable pressed level is edge 1.
- oENABLE is high in the cycle after edge DEBOUNCE_CYCLES+3.
- Release is debounced identically.

FSM (states IDLE, UP_HELD, DN_HELD, BOTH_HELD; one registered step decision per cycle):
- IDLE:
  - up pressed only: step up, go to UP_HELD, load rpt = REPEAT_DELAY.
  - down pressed only: step down, go to DN_HELD, load rpt = REPEAT_DELAY.
  - both pressed in the same cycle: go to BOTH_HELD, no step.
- UP_HELD / DN_HELD:
  - own key released: go to IDLE, no step.
  - other key pressed: go to BOTH_HELD, no step; pending repeat cancelled.
  - otherwise, if REPEAT_EN: decrement rpt. When rpt reaches 0, step in the held direction and reload rpt = REPEAT_PERIOD.
  - REPEAT_EN = 0: remain with no further steps.
- BOTH_HELD: no steps. Go to IDLE only when both keys are debounced-released.

Step:
- oUP_DOWN is set to the step direction even when the level does not change.
- Up:
  - level < MAX: level+1, oENABLE = 1.
  - level == MAX, WRAP = 0: level held, oENABLE = 0.
  - level == MAX, WRAP = 1: level = MIN_LEVEL, oENABLE = 1.
- Down: symmetric at MIN_LEVEL.
- oENABLE is never high for two consecutive cycles.

Arithmetic: the level register is unsigned WIDTH bits; no intermediate overflow is permitted.

Test Plan:
Common parameters: WIDTH=4, MIN=0, MAX=9, RESET_LEVEL=5, DEBOUNCE_CYCLES=4, REPEAT_DELAY=20, REPEAT_PERIOD=8, WRAP=0.

1. Hold iRST, release it, idle 10 cycles -> oLEVEL=5, oENABLE=0, oUP_DOWN=0, oAT_MAX=0, oAT_MIN=0.
2. Press up for 12 cycles with 2-cycle glitches before it, then release -> exactly one oENABLE pulse 7 edges after the stable press, oLEVEL=6, oUP_DOWN=1; glitches produce nothing.
3. Hold down for 60 cycles -> pulses at t0, t0+20, t0+28, t0+36, t0+44, t0+52; oLEVEL 5→4→3→2→1→0, then at 0 no pulse, oAT_MIN=1, oUP_DOWN=0.
4. From 9, press up once -> no pulse, oLEVEL=9, oUP_DOWN=1. Repeat with WRAP=1 -> pulse, oLEVEL=0.
5. Hold up 25 cycles past its first pulse, then press down -> no further steps in BOTH_HELD. Release down only -> still no steps. Release both, then press up -> one step.
6. Hold up across an iRST pulse at rpt=3 -> oLEVEL=5 immediately, no repeat pulse. After release of iRST, one pulse at DEBOUNCE_CYCLES+3 edges, oLEVEL=6.
